// File: rtl/hd44780_rx_pkg.sv
// rtl/hd44780_rx_pkg.sv - shared mode encodings, command constants and timing limits for hd44780_rx
package hd44780_rx_pkg;

    typedef enum logic [1:0] {
        M8    = 2'd0,
        M4_HI = 2'd1,
        M4_LO = 2'd2
    } mode_e;

    localparam logic [7:0] CMD_CLEAR    = 8'h01;
    localparam logic [7:0] CMD_HOME     = 8'h02;
    localparam logic [3:0] CMD_FSET4    = 4'h2;
    localparam logic [3:0] CMD_FSET8_HI = 4'h3;

    localparam int H4NS_COUNT_BITS  = 6;
    localparam int H4NS_TICKS_PWEH  = 4;
    localparam int H4NS_TICKS_TCYCE = 12;

    // Cursor address after an emitted byte; 8'h03 is a home command too.
    function automatic logic [6:0] next_addr(input logic [6:0] addr,
                                             input logic       rs,
                                             input logic [7:0] b);
        logic [6:0] res;
        res = addr;
        if (rs) begin
            res = addr + 7'd1;
        end else if (b == CMD_CLEAR || b[7:1] == CMD_HOME[7:1]) begin
            res = 7'd0;
        end else if (b[7]) begin
            res = b[6:0];
        end
        return res;
    endfunction

endpackage

// File: rtl/hd44780_rx_fifo.sv
// rtl/hd44780_rx_fifo.sv - first-word-fall-through FIFO with sticky overflow flag
module hd44780_rx_fifo #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 9
) (
    input  logic             CLK_I,
    input  logic             RST_I,
    input  logic             i_push,
    input  logic             i_pop,
    input  logic [WIDTH-1:0] i_din,
    output logic [WIDTH-1:0] o_head,
    output logic             o_empty,
    output logic             o_full,
    output logic             o_overflow
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_count;
    logic             r_overflow;
    logic             w_empty;
    logic             w_full;
    logic             w_do_pop;
    logic             w_do_push;

    assign w_empty   = (r_count == '0);
    assign w_full    = (r_count == FULL_CNT);
    assign w_do_pop  = i_pop & ~w_empty;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts the push.
    assign w_do_push = i_push & (~w_full | w_do_pop);

    always_ff @(posedge CLK_I) begin
        if (RST_I) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            if (w_do_push && !w_do_pop)      r_count <= r_count + 1'b1;
            else if (!w_do_push && w_do_pop) r_count <= r_count - 1'b1;
            if (i_push && !w_do_push) r_overflow <= 1'b1;
        end
    end

    always_ff @(posedge CLK_I) begin
        if (w_do_push) r_mem[r_wr_ptr] <= i_din;
    end

    assign o_head     = w_empty ? '0 : r_mem[r_rd_ptr];
    assign o_empty    = w_empty;
    assign o_full     = w_full;
    assign o_overflow = r_overflow;

endmodule

// File: rtl/hd44780_rx.sv
// rtl/hd44780_rx.sv - HD44780 4-bit bus receiver: sync, mode FSM, cursor tracking, FIFO.
// Optional bus timing checker enabled by H4RX_TIMING_CHECK_EN.
module hd44780_rx
    import hd44780_rx_pkg::*;
#(
    parameter int DEPTH = 16
) (
    input  logic       CLK_I,
    input  logic       RST_I,
    input  logic       i_lcd_e,
    input  logic       i_lcd_rs,
    input  logic [3:0] i_lcd_nybble,
    input  logic       i_pop,
    output logic [7:0] o_byte,
    output logic       o_rs,
    output logic       o_empty,
    output logic       o_full,
    output logic       o_overflow,
    output logic       o_mode4,
    output logic [6:0] o_ddram_addr,
    output logic       o_timing_err
);
    logic       r_e_s1, r_e_s2, r_e_prev;
    logic       r_rs_s1, r_rs_s2;
    logic [3:0] r_nyb_s1, r_nyb_s2;
    logic       r_cap_rs;
    logic [3:0] r_cap_nyb;
    logic       r_fall;
    logic [3:0] r_hi;
    logic [6:0] r_addr;
    mode_e      r_state;

    mode_e      w_state_next;
    logic       w_fall_now;
    logic       w_emit;
    logic [7:0] w_emit_byte;
    logic       w_load_hi;
    logic [8:0] w_head;

    assign w_fall_now = r_e_prev & ~r_e_s2;

    // Capture tracks the bus while E is high, so the fall uses the last high-cycle values.
    always_ff @(posedge CLK_I) begin
        if (RST_I) begin
            r_e_s1    <= 1'b0;
            r_e_s2    <= 1'b0;
            r_e_prev  <= 1'b0;
            r_rs_s1   <= 1'b0;
            r_rs_s2   <= 1'b0;
            r_nyb_s1  <= 4'h0;
            r_nyb_s2  <= 4'h0;
            r_cap_rs  <= 1'b0;
            r_cap_nyb <= 4'h0;
            r_fall    <= 1'b0;
        end else begin
            r_e_s1    <= i_lcd_e;
            r_e_s2    <= r_e_s1;
            r_e_prev  <= r_e_s2;
            r_rs_s1   <= i_lcd_rs;
            r_rs_s2   <= r_rs_s1;
            r_nyb_s1  <= i_lcd_nybble;
            r_nyb_s2  <= r_nyb_s1;
            r_fall    <= w_fall_now;
            if (r_e_s2) begin
                r_cap_rs  <= r_rs_s2;
                r_cap_nyb <= r_nyb_s2;
            end
        end
    end

    always_ff @(posedge CLK_I) begin
        if (RST_I) begin
            r_state <= M8;
            r_hi    <= 4'h0;
            r_addr  <= 7'd0;
        end else begin
            r_state <= w_state_next;
            if (w_load_hi) r_hi   <= r_cap_nyb;
            if (w_emit)    r_addr <= next_addr(r_addr, r_cap_rs, w_emit_byte);
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_emit       = 1'b0;
        w_emit_byte  = 8'h00;
        w_load_hi    = 1'b0;
        if (r_fall) begin
            case (r_state)
                M8: begin
                    w_emit      = 1'b1;
                    w_emit_byte = {r_cap_nyb, 4'h0};
                    if (!r_cap_rs && r_cap_nyb == CMD_FSET4) w_state_next = M4_HI;
                end
                M4_HI: begin
                    w_load_hi    = 1'b1;
                    w_state_next = M4_LO;
                end
                M4_LO: begin
                    w_emit       = 1'b1;
                    w_emit_byte  = {r_hi, r_cap_nyb};
                    w_state_next = (!r_cap_rs && r_hi == CMD_FSET8_HI) ? M8 : M4_HI;
                end
                default: w_state_next = M8;
            endcase
        end
    end

    hd44780_rx_fifo #(
        .DEPTH(DEPTH),
        .WIDTH(9)
    ) u_fifo (
        .CLK_I      (CLK_I),
        .RST_I      (RST_I),
        .i_push     (w_emit),
        .i_pop      (i_pop),
        .i_din      ({r_cap_rs, w_emit_byte}),
        .o_head     (w_head),
        .o_empty    (o_empty),
        .o_full     (o_full),
        .o_overflow (o_overflow)
    );

    assign o_rs         = w_head[8];
    assign o_byte       = w_head[7:0];
    assign o_mode4      = (r_state == M4_HI) || (r_state == M4_LO);
    assign o_ddram_addr = r_addr;

`ifdef H4RX_TIMING_CHECK_EN
    localparam logic [H4NS_COUNT_BITS-1:0] PWEH_T  = H4NS_COUNT_BITS'(H4NS_TICKS_PWEH);
    localparam logic [H4NS_COUNT_BITS-1:0] TCYCE_T = H4NS_COUNT_BITS'(H4NS_TICKS_TCYCE);

    logic                       w_rise;
    logic [H4NS_COUNT_BITS-1:0] r_pw_cnt;
    logic [H4NS_COUNT_BITS-1:0] r_cyc_cnt;
    logic                       r_seen_rise;
    logic                       r_timing_err;

    assign w_rise = r_e_s2 & ~r_e_prev;

    // Both counters start at 1 on a rise so they hold cycle counts, not cycle counts minus one.
    always_ff @(posedge CLK_I) begin
        if (RST_I) begin
            r_pw_cnt     <= '0;
            r_cyc_cnt    <= '0;
            r_seen_rise  <= 1'b0;
            r_timing_err <= 1'b0;
        end else begin
            if (r_cyc_cnt != '1) r_cyc_cnt <= r_cyc_cnt + 1'b1;
            if (w_rise) begin
                r_pw_cnt    <= 1;
                r_cyc_cnt   <= 1;
                r_seen_rise <= 1'b1;
                if (r_seen_rise && r_cyc_cnt < TCYCE_T) r_timing_err <= 1'b1;
            end else if (r_e_s2 && r_pw_cnt != '1) begin
                r_pw_cnt <= r_pw_cnt + 1'b1;
            end
            if (w_fall_now && r_pw_cnt < PWEH_T) r_timing_err <= 1'b1;
        end
    end

    assign o_timing_err = r_timing_err;
`else
    assign o_timing_err = 1'b0;
`endif

endmodule

// File: tb/tb_hd44780_rx.sv
// tb/tb_hd44780_rx.sv - self-checking bench for hd44780_rx against a byte-stream reference model
module tb_hd44780_rx;
    localparam int DEPTH = 4;
    localparam int HI_CYC = 6;

    logic       CLK_I = 1'b0;
    logic       RST_I = 1'b0;
    logic       i_lcd_e = 1'b0;
    logic       i_lcd_rs = 1'b0;
    logic [3:0] i_lcd_nybble = 4'h0;
    logic       i_pop = 1'b0;
    logic [7:0] o_byte;
    logic       o_rs;
    logic       o_empty;
    logic       o_full;
    logic       o_overflow;
    logic       o_mode4;
    logic [6:0] o_ddram_addr;
    logic       o_timing_err;

    hd44780_rx #(.DEPTH(DEPTH)) dut (
        .CLK_I        (CLK_I),
        .RST_I        (RST_I),
        .i_lcd_e      (i_lcd_e),
        .i_lcd_rs     (i_lcd_rs),
        .i_lcd_nybble (i_lcd_nybble),
        .i_pop        (i_pop),
        .o_byte       (o_byte),
        .o_rs         (o_rs),
        .o_empty      (o_empty),
        .o_full       (o_full),
        .o_overflow   (o_overflow),
        .o_mode4      (o_mode4),
        .o_ddram_addr (o_ddram_addr),
        .o_timing_err (o_timing_err)
    );

    always #5 CLK_I = ~CLK_I;

    int n_pass = 0;
    int n_total = 0;

    // Reference model: bytes as the LCD would see them, plus cursor and flags.
    logic [8:0] mq[$];
    bit         m_four;
    bit         m_have_hi;
    logic [3:0] m_hi;
    int         m_addr;
    bit         m_ovf;
    bit         m_terr;

    typedef struct {
        logic       rs;
        logic [3:0] nyb;
        logic       emit;
        logic [8:0] exp_head;
        logic       exp_mode4;
        logic [6:0] exp_addr;
    } vec_t;

    task automatic tick;
        @(posedge CLK_I);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic model_reset;
        mq.delete();
        m_four = 0;
        m_have_hi = 0;
        m_hi = 4'h0;
        m_addr = 0;
        m_ovf = 0;
        m_terr = 0;
    endtask

    task automatic model_emit(input logic rs, input logic [7:0] b);
        if (mq.size() < DEPTH) mq.push_back({rs, b});
        else m_ovf = 1;
        if (rs) m_addr = (m_addr + 1) % 128;
        else if (b == 8'h01 || b == 8'h02 || b == 8'h03) m_addr = 0;
        else if (b >= 8'h80) m_addr = b - 8'h80;
    endtask

    task automatic model_nybble(input logic rs, input logic [3:0] nyb);
        if (!m_four) begin
            model_emit(rs, {nyb, 4'h0});
            if (!rs && nyb == 4'h2) m_four = 1;
        end else if (!m_have_hi) begin
            m_hi = nyb;
            m_have_hi = 1;
        end else begin
            m_have_hi = 0;
            model_emit(rs, {m_hi, nyb});
            if (!rs && m_hi == 4'h3) m_four = 0;
        end
    endtask

    task automatic do_reset;
        i_lcd_e = 1'b0;
        i_pop = 1'b0;
        RST_I = 1'b1;
        tick();
        RST_I = 1'b0;
        model_reset();
    endtask

    // One E pulse; the FIFO write lands on the 4th edge after E drops.
    task automatic lcd_write(input logic rs, input logic [3:0] nyb, input int hi_cyc, input bit pop_at_push);
        i_lcd_rs = rs;
        i_lcd_nybble = nyb;
        i_lcd_e = 1'b1;
        repeat (hi_cyc) tick();
        i_lcd_e = 1'b0;
        repeat (3) tick();
        if (pop_at_push) i_pop = 1'b1;
        tick();
        i_pop = 1'b0;
        i_lcd_rs = $urandom_range(0, 1);
        i_lcd_nybble = 4'($urandom_range(0, 15));
        repeat (6) tick();
        if (pop_at_push && mq.size() > 0) void'(mq.pop_front());
        model_nybble(rs, nyb);
    endtask

    task automatic do_pop;
        i_pop = 1'b1;
        tick();
        i_pop = 1'b0;
        if (mq.size() > 0) void'(mq.pop_front());
    endtask

    task automatic check_all(input string tag);
        logic [8:0] h;
        check({tag, " empty"},    o_empty,      mq.size() == 0);
        check({tag, " full"},     o_full,       mq.size() == DEPTH);
        check({tag, " overflow"}, o_overflow,   m_ovf);
        check({tag, " mode4"},    o_mode4,      m_four);
        check({tag, " addr"},     o_ddram_addr, m_addr);
        check({tag, " terr"},     o_timing_err, m_terr);
        if (mq.size() > 0) begin
            h = mq[0];
            check({tag, " head"}, {o_rs, o_byte}, h);
        end
    endtask

    vec_t vecs[$];

    initial begin
        vecs = '{
            '{1'b0, 4'h3, 1'b1, 9'h030, 1'b0, 7'd0},
            '{1'b0, 4'h3, 1'b1, 9'h030, 1'b0, 7'd0},
            '{1'b0, 4'h3, 1'b1, 9'h030, 1'b0, 7'd0},
            '{1'b0, 4'h2, 1'b1, 9'h020, 1'b1, 7'd0},
            '{1'b0, 4'h8, 1'b0, 9'h000, 1'b1, 7'd0},
            '{1'b0, 4'h5, 1'b1, 9'h085, 1'b1, 7'd5},
            '{1'b1, 4'h4, 1'b0, 9'h000, 1'b1, 7'd5},
            '{1'b1, 4'h8, 1'b1, 9'h148, 1'b1, 7'd6},
            '{1'b0, 4'hF, 1'b0, 9'h000, 1'b1, 7'd6},
            '{1'b0, 4'hF, 1'b1, 9'h0FF, 1'b1, 7'd127},
            '{1'b1, 4'h4, 1'b0, 9'h000, 1'b1, 7'd127},
            '{1'b1, 4'h1, 1'b1, 9'h141, 1'b1, 7'd0},
            '{1'b0, 4'h8, 1'b0, 9'h000, 1'b1, 7'd0},
            '{1'b0, 4'hA, 1'b1, 9'h08A, 1'b1, 7'd10},
            '{1'b0, 4'h0, 1'b0, 9'h000, 1'b1, 7'd10},
            '{1'b0, 4'h1, 1'b1, 9'h001, 1'b1, 7'd0},
            '{1'b1, 4'h4, 1'b0, 9'h000, 1'b1, 7'd0},
            '{1'b1, 4'h1, 1'b1, 9'h141, 1'b1, 7'd1},
            '{1'b0, 4'h0, 1'b0, 9'h000, 1'b1, 7'd1},
            '{1'b0, 4'h3, 1'b1, 9'h003, 1'b1, 7'd0},
            '{1'b0, 4'h3, 1'b0, 9'h000, 1'b1, 7'd0},
            '{1'b0, 4'h8, 1'b1, 9'h038, 1'b0, 7'd0},
            '{1'b0, 4'h2, 1'b1, 9'h020, 1'b1, 7'd0}
        };

        model_reset();
        tick();
        do_reset();
        check("rst empty",    o_empty,      1'b1);
        check("rst full",     o_full,       1'b0);
        check("rst overflow", o_overflow,   1'b0);
        check("rst mode4",    o_mode4,      1'b0);
        check("rst terr",     o_timing_err, 1'b0);
        check("rst addr",     o_ddram_addr, 7'd0);
        check("rst byte",     o_byte,       8'h00);
        check("rst rs",       o_rs,         1'b0);

        foreach (vecs[i]) begin
            lcd_write(vecs[i].rs, vecs[i].nyb, HI_CYC, 1'b0);
            check($sformatf("vec%0d mode4", i), o_mode4,      vecs[i].exp_mode4);
            check($sformatf("vec%0d addr", i),  o_ddram_addr, vecs[i].exp_addr);
            check($sformatf("vec%0d empty", i), o_empty,      !vecs[i].emit);
            if (vecs[i].emit) begin
                check($sformatf("vec%0d head", i), {o_rs, o_byte}, vecs[i].exp_head);
                do_pop();
            end
        end

        // Fill to full, then push+pop on the same edge, then overflow.
        do_reset();
        lcd_write(1'b0, 4'h3, HI_CYC, 1'b0);
        lcd_write(1'b0, 4'h3, HI_CYC, 1'b0);
        lcd_write(1'b0, 4'h3, HI_CYC, 1'b0);
        lcd_write(1'b0, 4'h2, HI_CYC, 1'b0);
        check("fill full", o_full, 1'b1);
        check("fill mode4", o_mode4, 1'b1);
        check_all("fill");
        lcd_write(1'b0, 4'h8, HI_CYC, 1'b0);
        lcd_write(1'b0, 4'h5, HI_CYC, 1'b1);
        check("pushpop full", o_full, 1'b1);
        check("pushpop overflow", o_overflow, 1'b0);
        check_all("pushpop");
        lcd_write(1'b1, 4'h4, HI_CYC, 1'b0);
        lcd_write(1'b1, 4'h8, HI_CYC, 1'b0);
        check("ovf flag", o_overflow, 1'b1);
        check("ovf addr", o_ddram_addr, 7'd6);
        check_all("ovf");
        for (int i = 0; i < DEPTH; i++) begin
            do_pop();
            check_all($sformatf("drain%0d", i));
        end

        // Orphan high nybble discarded by reset.
        lcd_write(1'b0, 4'h8, HI_CYC, 1'b0);
        check("orphan pre mode4", o_mode4, 1'b1);
        do_reset();
        check("orphan mode4", o_mode4, 1'b0);
        check("orphan empty", o_empty, 1'b1);
        repeat (20) tick();
        check("orphan still empty", o_empty, 1'b1);

        // Randomized traffic against the model.
        do_reset();
        for (int i = 0; i < 60; i++) begin
            logic       rs;
            logic [3:0] nyb;
            rs  = $urandom_range(0, 1);
            nyb = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 4) == 0) begin
                rs  = 1'b0;
                nyb = 4'($urandom_range(2, 3));
            end
            lcd_write(rs, nyb, HI_CYC, $urandom_range(0, 5) == 0);
            if ($urandom_range(0, 2) != 0) do_pop();
            check_all($sformatf("rnd%0d", i));
        end

        // Short E pulse.
        do_reset();
        lcd_write(1'b0, 4'h3, hd44780_rx_pkg::H4NS_TICKS_PWEH - 1, 1'b0);
`ifdef H4RX_TIMING_CHECK_EN
        m_terr = 1;
        check("short pulse terr", o_timing_err, 1'b1);
`else
        check("short pulse terr", o_timing_err, 1'b0);
`endif
        lcd_write(1'b0, 4'h3, HI_CYC, 1'b0);
        check_all("terr sticky");

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
